prog_counter: RTL and testbench

- Parametrised successor to the fixed mod-N counter.
- Counts up or down over the inclusive range 0..limit, where limit is a runtime input.
- Supports synchronous load, enable gating, and three boundary modes: wrap, saturate and one-shot (FSM-controlled).
- Feeds sequencers and timers in the CPU datapath, which need terminal-count pulses and run/done status.

---
 rtl/prog_counter.sv | 148 ++++++++++++++
 tb/tb_prog_counter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// ---------------------------------------------------------------------------
// prog_counter
//   Up/down counter over the inclusive range 0..limit, where limit is a
//   runtime input. Supports a synchronous load, enable-gated stepping and
//   three behaviours at the range boundary: wrap, saturate and one-shot.
//   The one-shot mode is sequenced by a small FSM that reports run/done
//   status. A registered terminal-count pulse follows every boundary step.
//
// Ports
//   clk       in   clock, all state updates on the rising edge
//   rst       in   asynchronous reset, active low
//   en        in   step enable, one step per cycle while high
//   up        in   direction, 1 = increment, 0 = decrement
//   load      in   synchronous load of load_val (clamped to limit)
//   load_val  in   [WIDTH] value for load
//   start     in   one-shot launch, ignored outside ONE_SHOT mode
//   limit     in   [WIDTH] inclusive upper bound of the count range
//   mode      in   [2] 00 WRAP, 01 SATURATE, 10 ONE_SHOT, 11 treated as WRAP
//   out       out  [WIDTH] current count (registered)
//   tc        out  terminal-count pulse (registered)
//   busy      out  one-shot FSM in RUN
//   done      out  one-shot FSM in DONE
//
// One-shot FSM
//   state  | meaning
//   IDLE   | not counting; en ignored, out holds
//   RUN    | counting; en steps toward the boundary
//   DONE   | boundary reached; out holds until start or load
// ---------------------------------------------------------------------------
module prog_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0]       MODE_SAT     = 2'b01;
  localparam logic [1:0]       MODE_ONESHOT = 2'b10;
  localparam logic [WIDTH-1:0] ONE          = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO         = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             is_oneshot;
  logic             is_sat;
  logic             at_bound;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] wrap_val;
  logic [WIDTH-1:0] load_clamped;

  always_comb begin
    is_oneshot   = (mode == MODE_ONESHOT);
    is_sat       = (mode == MODE_SAT);
    // ">=" so a limit lowered below the current count still counts as the
    // boundary and pulls out back into range on the next step.
    at_bound     = up ? (cnt_q >= limit) : (cnt_q == ZERO);
    step_val     = up ? (cnt_q + ONE) : (cnt_q - ONE);
    // Wrap target doubles as the one-shot reinit value.
    wrap_val     = up ? ZERO : limit;
    load_clamped = (load_val > limit) ? limit : load_val;
  end

  always_comb begin
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    state_d = state_q;

    // Outside ONE_SHOT the FSM is parked in IDLE.
    if (!is_oneshot) begin
      state_d = S_IDLE;
    end

    if (load) begin
      cnt_d   = load_clamped;
      state_d = S_IDLE;
    end else if (is_oneshot && start) begin
      // Launch or restart from any state.
      cnt_d   = wrap_val;
      state_d = S_RUN;
    end else if (en) begin
      if (is_oneshot) begin
        if (state_q == S_RUN) begin
          if (at_bound) begin
            tc_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = step_val;
          end
        end
      end else if (at_bound) begin
        tc_d = 1'b1;
        if (!is_sat) begin
          cnt_d = wrap_val;
        end
      end else begin
        cnt_d = step_val;
      end
    end

    // Status flags are registered alongside the state so they always
    // reflect the state register.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = cnt_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_prog_counter.sv
// ---------------------------------------------------------------------------
// tb_prog_counter
//   Directed testbench for prog_counter (WIDTH = 4). Inputs are driven 1 ns
//   after each rising edge; outputs are sampled at the same point, so each
//   observation reflects the inputs presented before the preceding edge.
// ---------------------------------------------------------------------------
module tb_prog_counter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic [WIDTH-1:0] limit;
  logic [1:0]       mode;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             busy;
  logic             done;

  int n_checks;
  int n_errors;

  prog_counter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .limit    (limit),
    .mode     (mode),
    .out      (out),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int e_out, input int e_tc,
                         input int e_busy, input int e_done);
    chk({tag, ".out"},  32'(out),  32'(e_out));
    chk({tag, ".tc"},   32'(tc),   32'(e_tc));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  initial begin
    int exp_dn [4];
    int tc_dn  [4];
    int sat_o  [5];
    int sat_t  [5];
    int sdn_o  [4];
    int sdn_t  [4];

    n_checks = 0;
    n_errors = 0;

    rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    start = 1'b0; limit = 4'd9; mode = 2'b00;
    #3;
    chk_all("reset", 0, 0, 0, 0);
    #9 rst = 1'b1;                  // released between edges
    @(posedge clk); #1;
    chk_all("post_reset_idle", 0, 0, 0, 0);

    // Basic WRAP up count, limit 9
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("wrap_up[%0d].out", i), 32'(out), 32'((i + 1) % 10));
      chk($sformatf("wrap_up[%0d].tc", i),  32'(tc),  32'(i == 9));
    end
    // out is 2 here; asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    chk("async_rst.out", 32'(out), 32'd0);
    chk("async_rst.tc",  32'(tc),  32'd0);
    en = 1'b0;
    #3 rst = 1'b1;
    tick();

    // Down / wrap, limit 5
    limit = 4'd5; load = 1'b1; load_val = 4'd2;
    tick();
    chk_all("dn_load", 2, 0, 0, 0);
    load = 1'b0; up = 1'b0; en = 1'b1;
    exp_dn = '{1, 0, 5, 4};
    tc_dn  = '{0, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("wrap_dn[%0d].out", i), 32'(out), 32'(exp_dn[i]));
      chk($sformatf("wrap_dn[%0d].tc", i),  32'(tc),  32'(tc_dn[i]));
    end
    en = 1'b0; load = 1'b1; load_val = 4'd12;
    tick();
    chk_all("load_clamp", 5, 0, 0, 0);

    // SATURATE, limit 3
    mode = 2'b01; limit = 4'd3; load_val = 4'd0;
    tick();
    chk("sat_load.out", 32'(out), 32'd0);
    load = 1'b0; up = 1'b1; en = 1'b1;
    sat_o = '{1, 2, 3, 3, 3};
    sat_t = '{0, 0, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("sat_up[%0d].out", i), 32'(out), 32'(sat_o[i]));
      chk($sformatf("sat_up[%0d].tc", i),  32'(tc),  32'(sat_t[i]));
    end
    up = 1'b0;
    sdn_o = '{2, 1, 0, 0};
    sdn_t = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("sat_dn[%0d].out", i), 32'(out), 32'(sdn_o[i]));
      chk($sformatf("sat_dn[%0d].tc", i),  32'(tc),  32'(sdn_t[i]));
    end
    chk("sat_busy", 32'(busy), 32'd0);

    // ONE_SHOT, limit 4
    en = 1'b0; mode = 2'b10; limit = 4'd4; up = 1'b1;
    load = 1'b1; load_val = 4'd2;
    tick();
    chk_all("os_load", 2, 0, 0, 0);
    load = 1'b0; en = 1'b1;
    tick();
    chk_all("os_idle_en0", 2, 0, 0, 0);
    tick();
    chk_all("os_idle_en1", 2, 0, 0, 0);
    en = 1'b0; start = 1'b1;
    tick();
    chk_all("os_start", 0, 0, 1, 0);
    start = 1'b0; en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_all($sformatf("os_run[%0d]", i), i, 0, 1, 0);
    end
    tick();
    chk_all("os_done", 4, 1, 0, 1);
    tick();
    chk_all("os_done_hold", 4, 0, 0, 1);
    en = 1'b0; start = 1'b1;
    tick();
    chk_all("os_restart", 0, 0, 1, 0);
    start = 1'b0; en = 1'b1;
    tick();
    tick();
    chk_all("os_run2", 2, 0, 1, 0);
    start = 1'b1;                   // restart while running
    tick();
    chk_all("os_restart_run", 0, 0, 1, 0);
    start = 1'b0;
    tick();
    chk_all("os_run3", 1, 0, 1, 0);
    load = 1'b1; load_val = 4'd3;
    tick();
    chk_all("os_load_abort", 3, 0, 0, 0);

    // Priority: load beats start and en
    load = 1'b1; load_val = 4'd1; start = 1'b1; en = 1'b1;
    tick();
    chk_all("prio_load", 1, 0, 0, 0);
    load = 1'b0; start = 1'b0;

    // limit = 0 in WRAP: every step is a boundary step
    mode = 2'b00; limit = 4'd0; up = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("lim0[%0d].out", i), 32'(out), 32'd0);
      chk($sformatf("lim0[%0d].tc", i),  32'(tc),  32'd1);
    end

    // Lowering limit below the count
    en = 1'b0; limit = 4'd9; load = 1'b1; load_val = 4'd7;
    tick();
    chk("lower_lim_load.out", 32'(out), 32'd7);
    load = 1'b0; limit = 4'd3;
    tick();
    chk("lower_lim_hold.out", 32'(out), 32'd7);
    en = 1'b1;
    tick();
    chk("lower_lim_step.out", 32'(out), 32'd0);
    chk("lower_lim_step.tc",  32'(tc),  32'd1);

    // Leaving ONE_SHOT while in RUN
    en = 1'b0; mode = 2'b10; limit = 4'd9; start = 1'b1;
    tick();
    chk_all("leave_os_run", 0, 0, 1, 0);
    start = 1'b0; en = 1'b1;
    tick();
    chk_all("leave_os_step", 1, 0, 1, 0);
    mode = 2'b00; en = 1'b0;
    tick();
    chk_all("leave_os_wrap", 1, 0, 0, 0);

    // Reserved mode behaves as WRAP; start ignored
    mode = 2'b11; limit = 4'd2; load = 1'b1; load_val = 4'd2;
    tick();
    load = 1'b0; en = 1'b1; start = 1'b1;
    tick();
    chk_all("mode11_wrap", 0, 1, 0, 0);
    start = 1'b0;
    tick();
    chk_all("mode11_next", 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
